flex_down_timer: RTL and testbench

Loadable down-counting timer; counterpart to the team's up-counting flex_counter.
- Software/FSM loads a count, block decrements on enabled cycles, and emits a one-cycle expire pulse at zero.
- Supports one-shot or periodic auto-reload. Used as the timeout/interval source beside flex_counter in the team project datapath.

---
 rtl/flex_timer_pkg.sv | 12 +
 rtl/flex_prescaler.sv | 28 ++
 rtl/flex_down_timer.sv | 109 ++++++++++
 tb/tb_flex_down_timer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/flex_timer_pkg.sv
// Shared types and defaults for the flex_down_timer block and its prescaler.
package flex_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int unsigned NUM_BITS_DEF      = 4;
  localparam int unsigned PRESCALE_BITS_DEF = 4;

endpackage

// File: rtl/flex_prescaler.sv
// Tick generator: one tick per (prescale_val + 1) enabled cycles.
// Used by flex_down_timer only when FLEX_TIMER_PRESCALE_EN is defined.
module flex_prescaler
  import flex_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_BITS = PRESCALE_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_zero,
  input  logic                     i_en,
  input  logic [PRESCALE_BITS-1:0] i_prescale_val,
  output logic                     o_tick_c
);

  logic [PRESCALE_BITS-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == i_prescale_val);

  always_ff @(posedge clk) begin
    if (rst || i_zero || o_tick_c) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + PRESCALE_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_down_timer.sv
// Loadable down-counting timer with one-shot or periodic auto-reload.
// Optional decrement prescaler enabled by defining FLEX_TIMER_PRESCALE_EN.
module flex_down_timer
  import flex_timer_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEF
`ifdef FLEX_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE_BITS = PRESCALE_BITS_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_BITS-1:0]      load_val,
  input  logic                     count_enable,
  input  logic                     periodic,
`ifdef FLEX_TIMER_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_BITS-1:0]      count_out,
  output logic                     expire,
  output logic                     busy
);

  timer_state_t        r_state;
  timer_state_t        w_state_nxt;
  logic [NUM_BITS-1:0] r_count;
  logic [NUM_BITS-1:0] w_count_nxt;
  logic [NUM_BITS-1:0] r_reload;
  logic [NUM_BITS-1:0] w_reload_nxt;
  logic                r_expire;
  logic                w_expire_nxt;
  logic                r_busy;
  logic                w_tick;
  logic                w_at_one;

  assign w_at_one = (r_count == NUM_BITS'(1));

`ifdef FLEX_TIMER_PRESCALE_EN
  logic w_expiring;

  // Expiry restarts the prescale phase so every period has the same length
  assign w_expiring = (r_state == RUN) && w_tick && w_at_one;

  flex_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk            (clk),
    .rst            (rst),
    .i_zero         (clear || load || w_expiring),
    .i_en           (count_enable && (r_state == RUN)),
    .i_prescale_val (prescale_val),
    .o_tick_c       (w_tick)
  );
`else
  assign w_tick = count_enable;
`endif

  // Next-state: clear > load > decrement
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_expire_nxt = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
      w_state_nxt = IDLE;
    end else if (load) begin
      w_reload_nxt = load_val;
      w_count_nxt  = load_val;
      w_state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if ((r_state == RUN) && w_tick) begin
      if (w_at_one) begin
        w_expire_nxt = 1'b1;
        if (periodic) begin
          w_count_nxt = r_reload;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
      end else begin
        w_count_nxt = r_count - NUM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_expire <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_expire <= w_expire_nxt;
      r_busy   <= (w_state_nxt == RUN);
    end
  end

  assign count_out = r_count;
  assign expire    = r_expire;
  assign busy      = r_busy;

endmodule

// File: tb/tb_flex_down_timer.sv
// Scoreboard bench for flex_down_timer: a behavioural model queues the expected
// outputs per cycle and a monitor compares them. Honours FLEX_TIMER_PRESCALE_EN.
module tb_flex_down_timer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       count_enable;
  logic       periodic;
  logic [3:0] count_out;
  logic       expire;
  logic       busy;
  logic [3:0] tb_psv;

  typedef struct {
    int cnt;
    bit exp;
    bit bsy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   done   = 0;

  // Reference model state
  int m_cnt    = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_exp    = 0;
  int m_ps     = 0;

  flex_down_timer #(
    .NUM_BITS (4)
`ifdef FLEX_TIMER_PRESCALE_EN
    ,
    .PRESCALE_BITS (4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .periodic     (periodic),
`ifdef FLEX_TIMER_PRESCALE_EN
    .prescale_val (tb_psv),
`endif
    .count_out    (count_out),
    .expire       (expire),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Model of one clock edge, written from the timer's rules
  task automatic model(input bit r, input bit c, input bit l, input int lv,
                       input bit en, input bit p);
    bit tick;
    m_exp = 0;
    if (r) begin
      m_cnt = 0; m_run = 0; m_reload = 0; m_ps = 0;
    end else if (c) begin
      m_cnt = 0; m_run = 0; m_ps = 0;
    end else if (l) begin
      m_reload = lv; m_cnt = lv; m_run = (lv != 0); m_ps = 0;
    end else if (m_run && en) begin
`ifdef FLEX_TIMER_PRESCALE_EN
      if (m_ps == int'(tb_psv)) begin
        tick = 1; m_ps = 0;
      end else begin
        tick = 0; m_ps = (m_ps + 1) % 16;
      end
`else
      tick = 1;
`endif
      if (tick) begin
        if (m_cnt == 1) begin
          m_exp = 1;
          m_ps  = 0;
          if (p) m_cnt = m_reload;
          else begin
            m_cnt = 0; m_run = 0;
          end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs, advance the model, queue the expected outputs
  task automatic step(input bit r, input bit c, input bit l, input int lv,
                      input bit en, input bit p);
    exp_t e;
    rst = r; clear = c; load = l; load_val = 4'(lv);
    count_enable = en; periodic = p;
    model(r, c, l, lv, en, p);
    @(posedge clk);
    e.cnt = m_cnt; e.exp = m_exp; e.bsy = m_run;
    q.push_back(e);
    #1;
  endtask

  // Monitor: compare each registered output sample against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count_out", int'(count_out), e.cnt);
        chk("expire", int'(expire), int'(e.exp));
        chk("busy", int'(busy), int'(e.bsy));
      end
    end
  end

  initial begin
    int pulses;
    clk = 0; rst = 1; clear = 0; load = 0; load_val = '0;
    count_enable = 0; periodic = 0; tb_psv = '0;
    @(posedge clk); #1;

    // Reset dominates a load
    step(1, 0, 1, 9, 1, 0);
    step(1, 0, 1, 9, 1, 0);
    chk("reset_count", int'(count_out), 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // One-shot of 5
    step(0, 0, 1, 5, 1, 0);
    chk("oneshot_load", int'(count_out), 5);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    chk("oneshot_expire", int'(expire), 1);
    chk("oneshot_busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

    // Periodic of 3: 3 pulses in 9 enabled cycles
    step(0, 0, 1, 3, 1, 1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 1, 1);
      pulses += int'(expire);
    end
    chk("periodic_pulses", pulses, 3);
    chk("periodic_busy", int'(busy), 1);

    // Enable gating
    step(0, 0, 1, 7, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("gate_count", int'(count_out), 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("gate_expire", int'(expire), 1);

    // Simultaneous events
    step(0, 0, 1, 6, 1, 0);
    step(0, 1, 1, 4, 1, 0);
    chk("clear_load", int'(count_out), 0);
    step(0, 0, 1, 2, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 8, 1, 0);
    chk("reload_at_one", int'(count_out), 8);
    chk("reload_no_expire", int'(expire), 0);
    step(0, 0, 1, 0, 1, 0);
    chk("zero_load_busy", int'(busy), 0);
    step(0, 0, 0, 0, 1, 0);

`ifdef FLEX_TIMER_PRESCALE_EN
    tb_psv = 4'd2;
    step(0, 0, 1, 2, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    chk("prescale_no_early", int'(expire), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("prescale_expire", int'(expire), 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
`ifdef FLEX_TIMER_PRESCALE_EN
      if (i % 200 == 0) tb_psv = 4'($urandom_range(0, 3));
`endif
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
